// File: rtl/fetch_sequencer.sv
// fetch_sequencer: byte-serial instruction fetch (4 reads per word), PC ownership,
// redirect handling and valid/ready hand-off of the assembled word.
module fetch_sequencer #(
  parameter int               WIDTH    = 64,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic [WIDTH-1:0] mem_addr,
  output logic             mem_re,
  input  logic [7:0]       mem_rdata,
  output logic [31:0]      instr,
  output logic [WIDTH-1:0] instr_pc,
  output logic             instr_valid,
  input  logic             instr_ready,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             misaligned
);
  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DRAIN = 3'd2, HOLD = 3'd3, ERROR = 3'd4;
  logic [2:0]       state_q, state_d;
  logic [1:0]       k_q, k_d;
  logic [WIDTH-1:0] pc_q, pc_d, addr_q, addr_d, ipc_q, ipc_d;
  logic [31:0]      instr_q, instr_d;
  logic [23:0]      buf_q, buf_d;
  logic             pend_q, valid_q, valid_d, mis_q, mis_d;
  assign mem_re      = state_q == FETCH;
  assign mem_addr    = addr_q;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = valid_q;
  assign misaligned  = mis_q;
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    pc_d    = pc_q;
    ipc_d   = ipc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    mis_d   = mis_q;
    // bytes arrive in issue order, so shifting in builds {b0,b1,b2}
    buf_d   = pend_q && !redirect ? {buf_q[15:0], mem_rdata} : buf_q;
    if (redirect) begin
      valid_d = 1'b0;
      k_d     = 2'd0;
      mis_d   = |redirect_pc[1:0];
      pc_d    = mis_d ? pc_q : redirect_pc;
      state_d = mis_d ? ERROR : run ? FETCH : IDLE;
    end else begin
      case (state_q)
        IDLE:  state_d = run ? FETCH : IDLE;
        FETCH: begin
          k_d     = k_q + 2'd1;
          state_d = k_q == 2'd3 ? DRAIN : FETCH;
        end
        DRAIN: begin
          instr_d = {buf_q, mem_rdata};
          ipc_d   = pc_q;
          valid_d = 1'b1;
          state_d = HOLD;
        end
        HOLD: if (valid_q && instr_ready) begin
          pc_d    = pc_q + WIDTH'(4);
          valid_d = 1'b0;
          state_d = run ? FETCH : IDLE;
        end
        default: state_d = ERROR;
      endcase
    end
    addr_d = state_d == FETCH ? pc_d + WIDTH'(k_d) : addr_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
      ipc_q   <= '0;
      instr_q <= '0;
      buf_q   <= '0;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      ipc_q   <= ipc_d;
      instr_q <= instr_d;
      buf_q   <= buf_d;
      pend_q  <= mem_re && !redirect;
      valid_q <= valid_d;
      mis_q   <= mis_d;
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scenarios followed by randomized redirect/backpressure
// traffic checked against a word-level PC model over a random byte memory.
module tb_fetch_sequencer;
  localparam int W = 64;
  logic         clk = 1'b0, rst = 1'b1, run = 1'b0, instr_ready = 1'b0, redirect = 1'b0;
  logic [W-1:0] redirect_pc = '0, mem_addr, instr_pc;
  logic         mem_re, instr_valid, misaligned;
  logic [7:0]   mem_rdata;
  logic [31:0]  instr;
  logic [7:0]   mem [1024];
  int           checks = 0, failures = 0;
  always #5 clk = ~clk;
  fetch_sequencer #(.WIDTH(W), .RESET_PC(64'd0)) dut (
    .clk(clk), .rst(rst), .run(run), .mem_addr(mem_addr), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .misaligned(misaligned)
  );
  // synchronous-read memory; garbage on idle cycles exposes stray captures
  always @(posedge clk) mem_rdata <= mem_re ? mem[mem_addr[9:0]] : 8'($urandom);
  function automatic logic [31:0] word(input logic [W-1:0] p);
    logic [31:0] r = '0;
    logic [W-1:0] a;
    for (int i = 0; i < 4; i++) begin
      a = p + W'(i);
      r = {r[23:0], mem[a[9:0]]};
    end
    return r;
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wait_valid(input string tag, input int bound);
    int n = 0;
    while (!instr_valid && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, instr_valid, 1);
  endtask
  initial begin
    logic [W-1:0] exp_pc, t;
    logic         exp_mis, prev_redir;
    int           presented;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h00; mem[1] = 8'hA0; mem[2] = 8'h00; mem[3] = 8'h93;
    repeat (2) @(negedge clk);
    chk("rst_re", mem_re, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_mis", misaligned, 0);
    rst = 1'b0; run = 1'b1; instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("f0_re", mem_re, 1);
      chk("f0_addr", mem_addr, 64'(k));
    end
    @(negedge clk);
    chk("drain_re", mem_re, 0);
    chk("drain_valid", instr_valid, 0);
    @(negedge clk);
    chk("f0_valid", instr_valid, 1);
    chk("f0_instr", instr, 32'h00A00093);
    chk("f0_pc", instr_pc, 0);
    @(negedge clk);
    chk("f0_onecyc", instr_valid, 0);
    chk("f4_re", mem_re, 1);
    chk("f4_addr", mem_addr, 64'h4);
    instr_ready = 1'b0;
    repeat (5) @(negedge clk);
    chk("bp_valid", instr_valid, 1);
    chk("bp_pc", instr_pc, 64'h4);
    chk("bp_instr", instr, word(64'h4));
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", instr_valid, 1);
      chk("bp_hold_instr", instr, word(64'h4));
      chk("bp_hold_pc", instr_pc, 64'h4);
      chk("bp_hold_re", mem_re, 0);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    chk("bp_acc_valid", instr_valid, 0);
    chk("bp_acc_re", mem_re, 1);
    chk("bp_acc_addr", mem_addr, 64'h8);
    repeat (5) @(negedge clk);
    chk("hs_valid", instr_valid, 1);
    chk("hs_pc", instr_pc, 64'h8);
    chk("hs_instr", instr, word(64'h8));
    redirect = 1'b1; redirect_pc = 64'h100;
    @(negedge clk);
    redirect = 1'b0;
    chk("hs_rd_valid", instr_valid, 0);
    chk("hs_rd_addr", mem_addr, 64'h100);
    repeat (5) @(negedge clk);
    chk("hs_nxt_valid", instr_valid, 1);
    chk("hs_nxt_pc", instr_pc, 64'h100);
    chk("hs_nxt_instr", instr, word(64'h100));
    repeat (3) @(negedge clk);
    chk("k2_addr", mem_addr, 64'h106);
    redirect = 1'b1; redirect_pc = 64'h40;
    @(negedge clk);
    redirect = 1'b0;
    chk("k2_rd_re", mem_re, 1);
    chk("k2_rd_addr", mem_addr, 64'h40);
    wait_valid("k2", 10);
    chk("k2_pc", instr_pc, 64'h40);
    chk("k2_instr", instr, word(64'h40));
    redirect = 1'b1; redirect_pc = 64'h42;
    @(negedge clk);
    redirect = 1'b0;
    chk("mis_set", misaligned, 1);
    chk("mis_valid", instr_valid, 0);
    for (int i = 0; i < 4; i++) begin
      chk("mis_re", mem_re, 0);
      @(negedge clk);
    end
    chk("mis_sticky", misaligned, 1);
    redirect = 1'b1; redirect_pc = 64'h80;
    @(negedge clk);
    redirect = 1'b0;
    chk("mis_clr", misaligned, 0);
    chk("mis_rec_re", mem_re, 1);
    chk("mis_rec_addr", mem_addr, 64'h80);
    wait_valid("mis_rec", 10);
    chk("mis_rec_pc", instr_pc, 64'h80);
    chk("mis_rec_instr", instr, word(64'h80));
    repeat (2) @(negedge clk);
    chk("rstm_addr", mem_addr, 64'h85);
    #2 rst = 1'b1;
    #1;
    chk("rstm_re", mem_re, 0);
    chk("rstm_addr0", mem_addr, 0);
    chk("rstm_instr", instr, 0);
    chk("rstm_pc", instr_pc, 0);
    chk("rstm_valid", instr_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rstm_re1", mem_re, 1);
    chk("rstm_first", mem_addr, 0);
    wait_valid("rstm", 10);
    chk("rstm_instr2", instr, 32'h00A00093);
    redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    @(negedge clk);
    redirect = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("wrap_addr", mem_addr, 64'hFFFF_FFFF_FFFF_FFFC + 64'(k));
      @(negedge clk);
    end
    wait_valid("wrap", 10);
    chk("wrap_pc", instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_instr", instr, word(64'hFFFF_FFFF_FFFF_FFFC));
    @(negedge clk);
    chk("wrap_re", mem_re, 1);
    chk("wrap_zero", mem_addr, 0);
    exp_pc = '0; exp_mis = 1'b0; prev_redir = 1'b0; presented = 0;
    repeat (3000) begin
      if (prev_redir) chk("rnd_rd_valid", instr_valid, 0);
      chk("rnd_mis", misaligned, exp_mis);
      if (exp_mis) chk("rnd_err_re", mem_re, 0);
      if (instr_valid) begin
        chk("rnd_pc", instr_pc, exp_pc);
        chk("rnd_instr", instr, word(exp_pc));
        presented++;
      end
      redirect = $urandom_range(0, 11) == 0;
      t = {$urandom, $urandom};
      t[1:0] = $urandom_range(0, 3) == 0 ? 2'($urandom_range(1, 3)) : 2'd0;
      redirect_pc = t;
      instr_ready = $urandom_range(0, 9) < 7;
      run = $urandom_range(0, 9) != 0;
      if (redirect) begin
        if (t[1:0] == 2'd0) begin
          exp_pc = t;
          exp_mis = 1'b0;
        end else exp_mis = 1'b1;
      end else if (instr_valid && instr_ready) exp_pc = exp_pc + 64'd4;
      prev_redir = redirect;
      @(negedge clk);
    end
    redirect = 1'b0;
    chk("rnd_progress", presented > 50, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
